// File: rtl/div_32.sv
// div_32 -- sequential restoring divider.
//
// Divides a 2W-bit dividend by a W-bit divisor and produces one quotient bit
// per clock. A W-bit quotient and a W-bit remainder are returned. A zero
// divisor, or a quotient that would not fit in W bits, is flagged on err.
//
// Ports:
//   clk      in   1    system clock, rising edge
//   rst      in   1    synchronous reset, active high
//   init     in   1    start request; a rising edge in IDLE starts one operation
//   DV       in   2W   dividend, sampled on the start edge
//   DR       in   W    divisor, sampled on the start edge
//   C        out  W    quotient; holds the last result
//   R        out  W    remainder; holds the last result
//   busy     out  1    high from the start edge until done
//   done     out  1    one-cycle completion pulse
//   err      out  1    valid with done: divide-by-zero or quotient overflow
//   state_o  out  2    current FSM state (debug visibility)
//
// Handshake: the start is the clock edge where init=1, the previous init was 0
// and the FSM is IDLE. Inputs are captured on that edge. busy rises on it and
// falls in the same cycle as done. Rising init edges outside IDLE are dropped.
module div_32 #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic [2*W-1:0] DV,
  input  logic [W-1:0]   DR,
  output logic [W-1:0]   C,
  output logic [W-1:0]   R,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [1:0]     state_o
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            init_q;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dr_q, dr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_pend_q, err_pend_d;
  logic [W-1:0]    c_q, c_d;
  logic [W-1:0]    r_q, r_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            start;
  logic [W:0]      t;
  logic [W:0]      t_sub;
  logic            t_ge;
  logic [W-1:0]    rem_nx;
  logic [W-1:0]    quo_nx;

  assign start = init && !init_q && (state_q == S_IDLE);

  // One restoring step: shift the next dividend bit into the partial
  // remainder, compare and subtract on W+1 bits so the shifted-out MSB of the
  // remainder is not lost.
  assign t      = {rem_q, quo_q[W-1]};
  assign t_ge   = (t >= {1'b0, dr_q});
  assign t_sub  = t - {1'b0, dr_q};
  assign rem_nx = t_ge ? t_sub[W-1:0] : t[W-1:0];
  assign quo_nx = {quo_q[W-2:0], t_ge};

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dr_d       = dr_q;
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    c_d        = c_q;
    r_d        = r_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Dividend halves go straight into the remainder/quotient shifters.
          rem_d      = DV[2*W-1:W];
          quo_d      = DV[W-1:0];
          dr_d       = DR;
          err_pend_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        // A high half >= divisor means the quotient needs more than W bits.
        if ((dr_q == '0) || (rem_q >= dr_q)) begin
          err_pend_d = 1'b1;
          c_d        = '1;
          r_d        = '0;
          state_d    = S_DONE;
        end else begin
          cnt_d   = CW'(W);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          c_d     = quo_nx;
          r_d     = rem_nx;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // done/err are registered, so they appear in the cycle after this one.
        done_d  = 1'b1;
        err_d   = err_pend_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      init_q     <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dr_q       <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      c_q        <= '0;
      r_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_q     <= init;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dr_q       <= dr_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      c_q        <= c_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign C       = c_q;
  assign R       = r_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_div_32.sv
// tb_div_32 -- directed bench for the div_32 restoring divider.
module tb_div_32;

  logic        clk;
  logic        rst;
  logic        init;
  logic [31:0] DV;
  logic [15:0] DR;
  logic [15:0] C;
  logic [15:0] R;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_pass   = 0;

  div_32 #(.W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .init    (init),
    .DV      (DV),
    .DR      (DR),
    .C       (C),
    .R       (R),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .state_o (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Starts one operation and waits (bounded) for done. hold = number of
  // clock edges init stays high, counting the start edge. lat is the number
  // of posedges after the start edge at which done is first seen (0 = timeout).
  task automatic run_op(input logic [31:0] dv, input logic [15:0] dr, input int hold,
                        output int lat, output logic [15:0] c, output logic [15:0] r,
                        output logic e);
    lat = 0;
    c   = '0;
    r   = '0;
    e   = 1'b0;
    @(negedge clk);
    DV   = dv;
    DR   = dr;
    init = 1'b1;
    @(posedge clk);
    #1;
    if (hold <= 1) init = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n >= hold - 1) init = 1'b0;
      if (done) begin
        lat = n;
        c   = C;
        r   = R;
        e   = err;
        break;
      end
    end
    init = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  // Directed vectors: dividend, divisor, expected quotient, remainder, err, latency
  typedef struct {
    logic [31:0] dv;
    logic [15:0] dr;
    logic [15:0] c;
    logic [15:0] r;
    logic        e;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          lat;
    int          pulses;
    logic [15:0] c;
    logic [15:0] r;
    logic        e;
    logic        stable;

    vecs[0] = '{32'h00007A89, 16'h007F, 16'h00F7, 16'h0000, 1'b0, 18, "mult_inverse"};
    vecs[1] = '{32'h00010005, 16'h0010, 16'h1000, 16'h0005, 1'b0, 18, "rem5"};
    vecs[2] = '{32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 18, "max"};
    vecs[3] = '{32'h12345678, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 2,  "div_zero"};
    vecs[4] = '{32'h00100000, 16'h0010, 16'hFFFF, 16'h0000, 1'b1, 2,  "overflow"};

    rst  = 1'b1;
    init = 1'b0;
    DV   = '0;
    DR   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_C",    C,    0);
    check_eq("rst_R",    R,    0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err",  err,  0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].dv, vecs[i].dr, 1, lat, c, r, e);
      check_eq({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check_eq({vecs[i].name, "_C"},   c,   vecs[i].c);
      check_eq({vecs[i].name, "_R"},   r,   vecs[i].r);
      check_eq({vecs[i].name, "_err"}, e,   vecs[i].e);
      check_eq({vecs[i].name, "_busy_at_done"}, busy, 0);
      @(posedge clk);
      #1;
      check_eq({vecs[i].name, "_done_1cyc"}, done, 0);
      check_eq({vecs[i].name, "_err_1cyc"},  err,  0);
      repeat (2) @(posedge clk);
    end

    // init held high for 3 cycles: one operation only
    run_op(32'h00007A89, 16'h007F, 3, lat, c, r, e);
    check_eq("hold_lat", lat, 18);
    check_eq("hold_C",   c,   16'h00F7);
    count_done(30, pulses);
    check_eq("hold_extra_pulses", pulses, 0);

    // Second init edge while busy is ignored; C/R hold old result meanwhile
    @(negedge clk);
    DV   = 32'h00010005;
    DR   = 16'h0010;
    init = 1'b1;
    @(posedge clk);
    #1;
    init   = 1'b0;
    stable = 1'b1;
    lat    = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 5) begin
        DV   = 32'h00000009;
        DR   = 16'h0003;
        init = 1'b1;
      end
      if (n == 7) init = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (n < 17 && (C !== 16'h00F7 || R !== 16'h0000)) stable = 1'b0;
    end
    check_eq("busy_edge_CR_stable", stable, 1);
    check_eq("busy_edge_lat", lat, 18);
    check_eq("busy_edge_C",   C,   16'h1000);
    check_eq("busy_edge_R",   R,   16'h0005);
    count_done(30, pulses);
    check_eq("busy_edge_no_second", pulses, 0);

    // Reset during ITER aborts the operation
    @(negedge clk);
    DV   = 32'hFFFE0001;
    DR   = 16'hFFFF;
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("pre_rst_state_iter", state_o, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_C",    C,    0);
    check_eq("abort_R",    R,    0);
    count_done(30, pulses);
    check_eq("abort_no_done", pulses, 0);
    run_op(32'h00007A89, 16'h007F, 1, lat, c, r, e);
    check_eq("after_abort_lat", lat, 18);
    check_eq("after_abort_C",   c,   16'h00F7);
    check_eq("after_abort_R",   r,   16'h0000);
    check_eq("after_abort_err", e,   0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
